// File: rtl/led_scan_seq.sv
// LED scan sequencer: steps a 3-bit decoder select every CNT_MAX+1 clocks with start/stop/hold control.
// Define SCAN_PINGPONG_EN to bounce at the sequence ends instead of wrapping modulo 8.
module led_scan_seq #(
  parameter int              CNT_W   = 16,
  parameter logic [CNT_W-1:0] CNT_MAX = 16'd49_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       hold,
  input  logic       dir,
  output logic [2:0] sel,
  output logic       busy,
  output logic       step_pulse,
  output logic       wrap_pulse
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic [2:0]       r_sel;
  logic             r_step;
  logic             r_wrap;

  logic w_tick;
  logic w_seqEnd;

  assign w_tick   = (r_cnt == CNT_MAX);
  assign w_seqEnd = r_dir ? (r_sel == 3'd0) : (r_sel == 3'd7);

  // Pulses default low every cycle; only a tick in RUN raises them.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_sel   <= 3'd0;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_step <= 1'b0;
      r_wrap <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !stop) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_dir   <= dir;
            r_sel   <= dir ? 3'd7 : 3'd0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sel   <= 3'd0;
          end else if (hold) begin
            r_state <= ST_HOLD;
          end else if (w_tick) begin
            r_cnt  <= '0;
            r_step <= 1'b1;
            r_wrap <= w_seqEnd;
            if (w_seqEnd) begin
`ifdef SCAN_PINGPONG_EN
              r_dir <= ~r_dir;
              r_sel <= r_dir ? 3'd1 : 3'd6;
`else
              r_sel <= r_dir ? 3'd7 : 3'd0;
`endif
            end else begin
              r_sel <= r_dir ? (r_sel - 3'd1) : (r_sel + 3'd1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          // Leaving HOLD does not count, so the frozen prescaler value resumes untouched.
          if (stop) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sel   <= 3'd0;
          end else if (!hold) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_sel   <= 3'd0;
        end
      endcase
    end
  end

  assign sel        = r_sel;
  assign busy       = (r_state != ST_IDLE);
  assign step_pulse = r_step;
  assign wrap_pulse = r_wrap;

endmodule
